// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle: fetch-side push port, decode-side pop port, flush and
// occupancy.
interface if_id_queue_if #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH   = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [PC_WIDTH-1:0]    in_pc;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic                   flush;
  logic [CNT_WIDTH-1:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/if_id_queue.sv
// In-order fetch-to-decode queue of pc/instr pairs with valid/ready on both sides and a
// synchronous flush for branch redirects.
module if_id_queue #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned CNT_WIDTH   = 2
) (
  input logic         clk,
  input logic         reset,
  if_id_queue_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  logic                   in_ready;
  logic                   out_valid;
  logic                   push;
  logic                   pop;
  logic                   we;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  always_comb begin
    in_ready  = (count_q < CNT_WIDTH'(DEPTH));
    out_valid = (count_q != '0);
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
    out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_WIDTH'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (we) begin
        pc_mem_q[wr_ptr_q]    <= bus.in_pc;
        instr_mem_q[wr_ptr_q] <= bus.in_instr;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_pc;
  assign bus.out_instr = out_instr;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue; a reference occupancy count and pair scoreboard predict every
// output, compared once per cycle just after the falling edge.
module tb_if_id_queue;
  localparam int PC_WIDTH    = 64;
  localparam int INSTR_WIDTH = 32;
  localparam int DEPTH       = 2;
  localparam int CNT_WIDTH   = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_id_queue_if #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) bus ();

  if_id_queue #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  pair_t       sb[$];
  int          m_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic        tog = 1'b1;
  logic        stall_q = 1'b0;
  logic [63:0] prev_pc = '0;
  logic        acc;

  function automatic logic [31:0] mk(input logic [63:0] pc);
    return 32'hA000_0000 + pc[31:0];
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check against the model, then advance the model.
  task automatic step(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, output logic accepted);
    logic  pop;
    pair_t tmp;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    if (stall_q && iv) chk("hold_pc", pc, prev_pc);
    chk("in_ready", bus.in_ready, m_cnt < DEPTH);
    chk("out_valid", bus.out_valid, m_cnt != 0);
    chk("count", bus.count, m_cnt);
    if (m_cnt != 0) begin
      chk("out_pc", bus.out_pc, sb[0].pc);
      chk("out_instr", bus.out_instr, sb[0].instr);
    end else begin
      chk("out_pc_idle", bus.out_pc, 0);
      chk("out_instr_idle", bus.out_instr, 0);
    end
    accepted = iv && (m_cnt < DEPTH) && !fl;
    pop      = ordy && (m_cnt != 0);
    stall_q  = iv && !(m_cnt < DEPTH) && !fl;
    prev_pc  = pc;
    if (fl) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      if (pop) begin
        tmp = sb.pop_front();
        m_cnt--;
      end
      if (accepted) begin
        sb.push_back({pc, ins});
        m_cnt++;
      end
    end
  endtask

  // mode 0: decode stalled, 1: decode ready, 2: decode ready toggles every cycle.
  task automatic push_hold(input logic [63:0] pc, input int mode);
    logic a;
    logic ordy;
    a = 1'b0;
    for (int k = 0; k < 8 && !a; k++) begin
      ordy = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : tog;
      step(1'b1, pc, mk(pc), ordy, 1'b0, a);
      tog = ~tog;
    end
    if (!a) begin
      total++;
      bad++;
      $error("FAIL push_timeout observed=%0h expected=accepted", pc);
    end
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 8 && m_cnt != 0; k++) step(1'b0, '0, '0, 1'b1, 1'b0, a);
    step(1'b0, '0, '0, 1'b0, 1'b0, a);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic pass
    step(1'b1, 64'h0, 32'h8B02_0020, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Fill to full, hold the third pair, then drain in order
    push_hold(64'h0, 0);
    push_hold(64'h4, 0);
    step(1'b1, 64'h8, mk(64'h8), 1'b0, 1'b0, acc);
    step(1'b1, 64'h8, mk(64'h8), 1'b0, 1'b0, acc);
    push_hold(64'h8, 1);
    drain();

    // Simultaneous push and pop at count 1
    push_hold(64'hC, 0);
    step(1'b1, 64'h10, mk(64'h10), 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Wrap-around stream with toggling decode ready
    for (int i = 0; i < 10; i++) push_hold(64'(i * 4), 2);
    drain();

    // Flush at full with a concurrent push
    push_hold(64'h20, 0);
    push_hold(64'h24, 0);
    step(1'b1, 64'h28, mk(64'h28), 1'b0, 1'b1, acc);
    step(1'b1, 64'h100, mk(64'h100), 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, acc);

    // Asynchronous reset between clock edges with two entries held
    push_hold(64'h40, 0);
    push_hold(64'h44, 0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_out_pc", bus.out_pc, 0);
    chk("arst_out_instr", bus.out_instr, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    sb.delete();
    m_cnt   = 0;
    stall_q = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    push_hold(64'h200, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
